// File: rtl/treeval_pkg.sv
// Shared definitions for treeval and its configuration/evaluation sequencer.
package treeval_pkg;

  localparam int unsigned W_ADDR   = 10;
  localparam int unsigned W_N_DATA = 11;
  localparam int unsigned W_C_DATA = 10;
  localparam int unsigned W_REWARD = 11;
  localparam int unsigned W_ACTION = 3;

  typedef enum logic [1:0] {
    KIND_PAR    = 2'd0,
    KIND_REW    = 2'd1,
    KIND_ACT    = 2'd2,
    KIND_WEIGHT = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONF  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_e;

  localparam logic [W_ACTION-1:0] ACT_PLAY    = 3'b001;
  localparam logic [W_ACTION-1:0] ACT_NO_PLAY = 3'b000;

  // One forwarded node write as presented on treeval's memory port.
  typedef struct packed {
    logic                par;
    logic                rew;
    logic                act;
    logic                weight;
    logic [W_ADDR-1:0]   addr;
    logic [W_N_DATA-1:0] data;
  } tv_mem_t;

endpackage

// File: rtl/treeval_ctrl.sv
// Sequences node-count config, typed node writes, evaluation reset and result
// capture for a single treeval instance.
module treeval_ctrl
  import treeval_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic [W_C_DATA-1:0] load_nodes,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_kind,
  input  logic [W_ADDR-1:0]   cmd_addr,
  input  logic [W_N_DATA-1:0] cmd_data,
  input  logic                cmd_last,
  input  logic                res_ack,
  output logic                busy,
  output logic                res_valid,
  output logic [W_REWARD-1:0] res_exp,
  output logic [W_ACTION-1:0] res_act,
  output logic                res_timeout,
  output logic                err_addr,
  output logic                tv_conf_nodes,
  output logic                tv_mem_par,
  output logic                tv_mem_rew,
  output logic                tv_mem_act,
  output logic                tv_mem_weight,
  output logic [W_C_DATA-1:0] tv_conf_data,
  output logic [W_ADDR-1:0]   tv_mem_addr,
  output logic [W_N_DATA-1:0] tv_mem_data,
  output logic                tv_rst,
  input  logic                tv_exp_change,
  input  logic [W_REWARD-1:0] tv_exp,
  input  logic [W_ACTION-1:0] tv_act
);

  localparam int unsigned     W_CNT   = $clog2(TIMEOUT + 1);
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(TIMEOUT);

  ctrl_state_e         state_q, state_d;
  logic [W_C_DATA-1:0] nodes_q, nodes_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d, cnt_inc;
  tv_mem_t             mem_q, mem_d;
  logic                conf_nodes_q, conf_nodes_d;
  logic [W_C_DATA-1:0] conf_data_q, conf_data_d;
  logic                tv_rst_q, tv_rst_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                res_valid_q, res_valid_d;
  logic [W_REWARD-1:0] res_exp_q, res_exp_d;
  logic [W_ACTION-1:0] res_act_q, res_act_d;
  logic                res_timeout_q, res_timeout_d;
  logic                err_q, err_d;
  logic                accept, drop;
  cmd_kind_e           kind;

  assign kind = cmd_kind_e'(cmd_kind);

  // Next state, result capture and the one-cycle-delayed strobe register.
  always_comb begin
    state_d       = state_q;
    nodes_d       = nodes_q;
    cnt_d         = cnt_q;
    mem_d         = '0;
    res_valid_d   = res_valid_q;
    res_exp_d     = res_exp_q;
    res_act_d     = res_act_q;
    res_timeout_d = res_timeout_q;
    err_d         = err_q;
    accept        = cmd_valid & cmd_ready_q;
    drop          = (cmd_addr >= nodes_q) ||
                    ((cmd_addr == '0) && ((kind == KIND_PAR) || (kind == KIND_WEIGHT)));
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + W_CNT'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_d     = ST_CONF;
          nodes_d     = load_nodes;
          err_d       = 1'b0;
          res_valid_d = 1'b0;
        end else if ((state_q == ST_DONE) && res_ack) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      ST_CONF: state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (drop) begin
            err_d = 1'b1;
          end else begin
            mem_d.addr = cmd_addr;
            mem_d.data = cmd_data;
            case (kind)
              KIND_PAR:    mem_d.par    = 1'b1;
              KIND_REW:    mem_d.rew    = 1'b1;
              KIND_ACT:    mem_d.act    = 1'b1;
              KIND_WEIGHT: mem_d.weight = 1'b1;
            endcase
          end
          if (cmd_last) state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A nonzero count means this is at least the second WAIT cycle.
        if (tv_exp_change && (cnt_q != '0)) begin
          state_d       = ST_DONE;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b0;
          res_exp_d     = tv_exp;
          res_act_d     = tv_act;
        end else if (cnt_inc == CNT_MAX) begin
          state_d       = ST_DONE;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
          res_exp_d     = '0;
          res_act_d     = ACT_NO_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    conf_nodes_d = (state_d == ST_CONF);
    conf_data_d  = (state_d == ST_CONF) ? nodes_d : '0;
    tv_rst_d     = (state_d == ST_START);
    cmd_ready_d  = (state_d == ST_LOAD);
    busy_d       = (state_d == ST_CONF) || (state_d == ST_LOAD) ||
                   (state_d == ST_START) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      nodes_q       <= '0;
      cnt_q         <= '0;
      mem_q         <= '0;
      conf_nodes_q  <= 1'b0;
      conf_data_q   <= '0;
      tv_rst_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_exp_q     <= '0;
      res_act_q     <= '0;
      res_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      nodes_q       <= nodes_d;
      cnt_q         <= cnt_d;
      mem_q         <= mem_d;
      conf_nodes_q  <= conf_nodes_d;
      conf_data_q   <= conf_data_d;
      tv_rst_q      <= tv_rst_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      res_exp_q     <= res_exp_d;
      res_act_q     <= res_act_d;
      res_timeout_q <= res_timeout_d;
      err_q         <= err_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign res_valid     = res_valid_q;
  assign res_exp       = res_exp_q;
  assign res_act       = res_act_q;
  assign res_timeout   = res_timeout_q;
  assign err_addr      = err_q;
  assign tv_conf_nodes = conf_nodes_q;
  assign tv_conf_data  = conf_data_q;
  assign tv_mem_par    = mem_q.par;
  assign tv_mem_rew    = mem_q.rew;
  assign tv_mem_act    = mem_q.act;
  assign tv_mem_weight = mem_q.weight;
  assign tv_mem_addr   = mem_q.addr;
  assign tv_mem_data   = mem_q.data;
  assign tv_rst        = tv_rst_q;

endmodule

// File: tb/tb_treeval_ctrl.sv
// Self-checking bench for treeval_ctrl: directed command tables plus randomized
// loads scored against a rule-level model; treeval itself is a driven stub.
module tb_treeval_ctrl;
  import treeval_pkg::*;

  localparam int TO = 16;

  logic                clk;
  logic                rst;
  logic                load_start;
  logic [W_C_DATA-1:0] load_nodes;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_kind;
  logic [W_ADDR-1:0]   cmd_addr;
  logic [W_N_DATA-1:0] cmd_data;
  logic                cmd_last;
  logic                res_ack;
  logic                busy;
  logic                res_valid;
  logic [W_REWARD-1:0] res_exp;
  logic [W_ACTION-1:0] res_act;
  logic                res_timeout;
  logic                err_addr;
  logic                tv_conf_nodes;
  logic                tv_mem_par, tv_mem_rew, tv_mem_act, tv_mem_weight;
  logic [W_C_DATA-1:0] tv_conf_data;
  logic [W_ADDR-1:0]   tv_mem_addr;
  logic [W_N_DATA-1:0] tv_mem_data;
  logic                tv_rst;
  logic                tv_exp_change;
  logic [W_REWARD-1:0] tv_exp;
  logic [W_ACTION-1:0] tv_act;

  treeval_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_nodes(load_nodes),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last),
    .res_ack(res_ack), .busy(busy), .res_valid(res_valid), .res_exp(res_exp),
    .res_act(res_act), .res_timeout(res_timeout), .err_addr(err_addr),
    .tv_conf_nodes(tv_conf_nodes), .tv_mem_par(tv_mem_par), .tv_mem_rew(tv_mem_rew),
    .tv_mem_act(tv_mem_act), .tv_mem_weight(tv_mem_weight),
    .tv_conf_data(tv_conf_data), .tv_mem_addr(tv_mem_addr), .tv_mem_data(tv_mem_data),
    .tv_rst(tv_rst), .tv_exp_change(tv_exp_change), .tv_exp(tv_exp), .tv_act(tv_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]          kind;
    logic [W_ADDR-1:0]   addr;
    logic [W_N_DATA-1:0] data;
    logic                last;
    bit                  fwd;
  } cmd_t;

  cmd_t cq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int kind, input int addr, input int data,
                              input bit last, input bit fwd);
    cmd_t c;
    c.kind = 2'(kind);
    c.addr = W_ADDR'(addr);
    c.data = W_N_DATA'(data);
    c.last = last;
    c.fwd  = fwd;
    return c;
  endfunction

  // A write reaches treeval only if its node exists; node 0 is the root and
  // has neither a parent nor an incoming weight.
  function automatic bit fwd_ok(input cmd_t c, input int nodes);
    if (int'(c.addr) >= nodes) return 1'b0;
    if (c.addr == '0 && (c.kind == 2'd0 || c.kind == 2'd3)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({cmd_ready, busy, res_valid, res_exp, res_act, res_timeout, err_addr,
                tv_conf_nodes, tv_mem_par, tv_mem_rew, tv_mem_act, tv_mem_weight,
                tv_conf_data, tv_mem_addr, tv_mem_data, tv_rst});
  endfunction

  task automatic check_strobe(input bit ev, input cmd_t c);
    logic [3:0] exp_s;
    logic [3:0] obs_s;
    obs_s = {tv_mem_weight, tv_mem_act, tv_mem_rew, tv_mem_par};
    exp_s = ev ? 4'(1 << c.kind) : 4'b0;
    if (ev) chk("strobe", 64'({obs_s, tv_mem_addr, tv_mem_data}), 64'({exp_s, c.addr, c.data}));
    else    chk("strobe_idle", 64'({obs_s, tv_mem_addr, tv_mem_data}), 64'(0));
  endtask

  task automatic do_load(input int nodes);
    @(negedge clk);
    load_nodes = W_C_DATA'(nodes);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("conf_pulse", 64'({tv_conf_nodes, tv_conf_data, cmd_ready, busy, err_addr, res_valid}),
        64'({1'b1, W_C_DATA'(nodes), 1'b0, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    chk("load_entry", 64'({tv_conf_nodes, tv_conf_data, cmd_ready, busy}),
        64'({1'b0, W_C_DATA'(0), 1'b1, 1'b1}));
  endtask

  // Entered on a LOAD-cycle negedge; leaves on the negedge after the last accept.
  task automatic run_cmds(input bit gaps, input bit exp_err);
    int   i;
    int   guard;
    bit   pend;
    bit   acc;
    cmd_t pc;
    i = 0; guard = 0; pend = 1'b0;
    pc = mk(0, 0, 0, 1'b0, 1'b0);
    while (1) begin
      check_strobe(pend, pc);
      if (i == cq.size()) break;
      if (guard++ > 500) begin
        checks++; failures++;
        $display("FAIL load_progress: accepted %0d of %0d writes", i, cq.size());
        break;
      end
      acc = 1'b0;
      if (!gaps || $urandom_range(0, 2) != 0) begin
        cmd_valid = 1'b1;
        cmd_kind  = cq[i].kind;
        cmd_addr  = cq[i].addr;
        cmd_data  = cq[i].data;
        cmd_last  = cq[i].last;
        chk("cmd_ready", 64'(cmd_ready), 64'(1));
        acc = cmd_ready;
      end else begin
        cmd_valid = 1'b0;
      end
      pend = acc && cq[i].fwd;
      if (acc) begin
        pc = cq[i];
        i++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    chk("err_addr", 64'(err_addr), 64'(exp_err));
  endtask

  task automatic check_start();
    chk("start", 64'({tv_rst, cmd_ready, busy, tv_conf_nodes}), 64'(4'b1010));
  endtask

  // Called on the START negedge; stub raises exp_change from WAIT cycle d on.
  task automatic wait_result(input int d, input logic [W_REWARD-1:0] ev,
                             input logic [W_ACTION-1:0] av, input bit ls);
    int cap;
    int endc;
    bit is_to;
    cap   = (d < 2) ? 2 : d;
    is_to = (cap > TO);
    endc  = is_to ? TO : cap;
    for (int c = 1; c <= endc; c++) begin
      @(negedge clk);
      chk("wait_state", 64'({res_valid, busy, tv_rst, tv_conf_nodes, cmd_ready}), 64'(5'b01000));
      tv_exp_change = (c >= d);
      tv_exp        = ev;
      tv_act        = av;
      load_start    = ls && (c == 3);
      load_nodes    = W_C_DATA'(3);
    end
    @(negedge clk);
    tv_exp_change = 1'b0;
    tv_exp        = '0;
    tv_act        = '0;
    load_start    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k != 0) @(negedge clk);
      chk("result", 64'({res_valid, res_timeout, res_exp, res_act, busy, tv_conf_nodes}),
          64'({1'b1, is_to, is_to ? W_REWARD'(0) : ev, is_to ? W_ACTION'(0) : av, 1'b0, 1'b0}));
    end
  endtask

  task automatic ack();
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("ack_idle", 64'({res_valid, busy, cmd_ready, tv_conf_nodes}), 64'(0));
  endtask

  initial begin
    int rv[5];
    int nodes;
    int n;
    bit any_drop;
    cmd_t c;
    rv = '{-10, 0, 100, -50, 10};
    rst = 1'b0; load_start = 1'b0; load_nodes = '0; cmd_valid = 1'b0;
    cmd_kind = '0; cmd_addr = '0; cmd_data = '0; cmd_last = 1'b0; res_ack = 1'b0;
    tv_exp_change = 1'b0; tv_exp = '0; tv_act = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", out_vec(), 64'(0));

    // Full tree load, exp_change raised already in the ignored first WAIT cycle.
    do_load(7);
    cq.delete();
    for (int a = 1; a <= 6; a++) cq.push_back(mk(KIND_PAR, a, (a > 3) ? 1 : 0, 1'b0, 1'b1));
    for (int a = 2; a <= 6; a++) cq.push_back(mk(KIND_REW, a, rv[a-2], 1'b0, 1'b1));
    for (int a = 1; a <= 6; a++)
      cq.push_back(mk(KIND_ACT, a, (a == 3 || a == 6) ? int'(ACT_NO_PLAY) : int'(ACT_PLAY), 1'b0, 1'b1));
    for (int a = 1; a <= 6; a++)
      cq.push_back(mk(KIND_WEIGHT, a, (a == 3 || a == 6) ? 128 : 64, a == 6, 1'b1));
    run_cmds(1'b0, 1'b0);
    check_start();
    wait_result(1, W_REWARD'(-5), ACT_PLAY, 1'b0);
    ack();

    // Back-to-back parent writes; load_start during WAIT must be ignored.
    do_load(7);
    cq.delete();
    for (int a = 1; a <= 6; a++) cq.push_back(mk(KIND_PAR, a, (a > 3) ? 1 : 0, a == 6, 1'b1));
    run_cmds(1'b0, 1'b0);
    check_start();
    wait_result(5, W_REWARD'(100), ACT_NO_PLAY, 1'b1);
    ack();

    // Drop rules, then a timeout.
    do_load(7);
    cq.delete();
    cq.push_back(mk(KIND_REW, 9, 33, 1'b0, 1'b0));
    cq.push_back(mk(KIND_WEIGHT, 0, 64, 1'b0, 1'b0));
    cq.push_back(mk(KIND_PAR, 0, 1, 1'b0, 1'b0));
    cq.push_back(mk(KIND_ACT, 7, 1, 1'b0, 1'b0));
    cq.push_back(mk(KIND_REW, 0, 5, 1'b0, 1'b1));
    cq.push_back(mk(KIND_ACT, 6, 1, 1'b1, 1'b1));
    run_cmds(1'b0, 1'b1);
    check_start();
    wait_result(40, W_REWARD'(9), ACT_PLAY, 1'b0);
    ack();

    // exp_change on the timeout cycle wins; then load_start with res_ack in DONE.
    do_load(3);
    cq.delete();
    cq.push_back(mk(KIND_REW, 1, 12, 1'b1, 1'b1));
    run_cmds(1'b0, 1'b0);
    check_start();
    wait_result(TO, W_REWARD'(77), ACT_PLAY, 1'b0);
    load_start = 1'b1; res_ack = 1'b1; load_nodes = W_C_DATA'(4);
    @(negedge clk);
    load_start = 1'b0; res_ack = 1'b0;
    chk("start_beats_ack", 64'({tv_conf_nodes, tv_conf_data, res_valid, busy}),
        64'({1'b1, W_C_DATA'(4), 1'b0, 1'b1}));
    @(negedge clk);
    chk("load_after_done", 64'({cmd_ready, tv_conf_nodes}), 64'(2'b10));
    cq.delete();
    cq.push_back(mk(KIND_ACT, 2, 1, 1'b1, 1'b1));
    run_cmds(1'b0, 1'b0);
    check_start();
    wait_result(3, W_REWARD'(-300), ACT_NO_PLAY, 1'b0);
    ack();

    // Reset in the middle of a load, then a fresh load.
    do_load(7);
    cq.delete();
    cq.push_back(mk(KIND_PAR, 1, 0, 1'b0, 1'b1));
    cq.push_back(mk(KIND_REW, 9, 4, 1'b0, 1'b0));
    cq.push_back(mk(KIND_ACT, 2, 1, 1'b0, 1'b1));
    run_cmds(1'b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_load_reset", out_vec(), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("after_mid_reset", out_vec(), 64'(0));
    do_load(5);
    cq.delete();
    cq.push_back(mk(KIND_WEIGHT, 4, 128, 1'b1, 1'b1));
    run_cmds(1'b0, 1'b0);
    check_start();
    wait_result(2, W_REWARD'(1), ACT_PLAY, 1'b0);
    ack();

    // Randomized loads with idle gaps and random exp_change timing.
    for (int it = 0; it < 10; it++) begin
      nodes = $urandom_range(1, 20);
      n     = $urandom_range(1, 10);
      any_drop = 1'b0;
      cq.delete();
      for (int k = 0; k < n; k++) begin
        c = mk($urandom_range(0, 3), $urandom_range(0, nodes + 2), $urandom, k == n - 1, 1'b0);
        c.fwd = fwd_ok(c, nodes);
        any_drop |= !c.fwd;
        cq.push_back(c);
      end
      do_load(nodes);
      run_cmds(1'b1, any_drop);
      check_start();
      wait_result($urandom_range(1, 20), W_REWARD'($urandom), W_ACTION'($urandom), 1'b0);
      ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/treeval_ctrl.md
Name: treeval_ctrl

Overview:
Sequencer that owns the configuration and evaluation interface of one treeval instance. It takes a node count and a valid/ready stream of typed node writes from a host. It issues the one-hot conf_nodes/mem_* strobes treeval expects, then pulses treeval's evaluation reset. It waits for exp_change, or a timeout, and returns exp/act to the host as a held result.

Parameters:
W_ADDR, 10, node address width
W_N_DATA, 11, node write data width
W_C_DATA, 10, node-count config width
W_REWARD, 11, expectation width (two's complement)
W_ACTION, 3, action code width
TIMEOUT, 64, max cycles waited for exp_change after evaluation starts

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
load_start  in  1  pulse: begin new tree load
load_nodes  in  W_C_DATA  node count, sampled with load_start
cmd_valid  in  1  host write valid
cmd_ready  out  1  high only in LOAD
cmd_kind  in  2  0=PAR 1=REW 2=ACT 3=WEIGHT
cmd_addr  in  W_ADDR  target node
cmd_data  in  W_N_DATA  parent / reward / action / weight
cmd_last  in  1  final write of this load
res_ack  in  1  host consumes result
busy  out  1  state not IDLE/DONE
res_valid  out  1  result held
res_exp  out  W_REWARD  captured expectation
res_act  out  W_ACTION  captured action
res_timeout  out  1  result is a timeout
err_addr  out  1  sticky: a write was dropped
tv_conf_nodes, tv_mem_par, tv_mem_rew, tv_mem_act, tv_mem_weight  out  1 each  treeval strobes
tv_conf_data  out  W_C_DATA  to treeval conf_data
tv_mem_addr  out  W_ADDR  to treeval mem_addr
tv_mem_data  out  W_N_DATA  to treeval mem_data
tv_rst  out  1  treeval evaluation reset (active-high)
tv_exp_change  in  1  from treeval
tv_exp  in  W_REWARD  from treeval
tv_act  in  W_ACTION  from treeval

Behaviour:
- Reset (rst=0 at an edge): state=IDLE. All outputs are registered and go to 0, including tv_rst, all strobes, res_*, and err_addr. The node count register clears. Reset mid-operation abandons the load. No strobe is emitted in the following cycle.
- States: IDLE, CONF, LOAD, START, WAIT, DONE.
- IDLE/DONE + load_start -> CONF. Latch load_nodes and clear err_addr. In DONE this also clears res_valid. load_start in any other state is ignored.
- CONF: one cycle with tv_conf_nodes=1 and tv_conf_data=latched count. Then -> LOAD.
- LOAD: cmd_ready=1. A write accepted (valid&ready) at edge k drives exactly one strobe, one-hot by cmd_kind, during cycle k+1, with tv_mem_addr/tv_mem_data equal to the accepted values. Back-to-back accepts give one strobe per cycle. When strobes are idle, addr and data are 0.
- Drop rule: a write is not forwarded and err_addr is set if cmd_addr >= node count, or if cmd_addr==0 with kind PAR or WEIGHT. A dropped write is still accepted, and its cmd_last still counts.
- Accepting cmd_last -> START. The last strobe, if any, overlaps the START cycle.
- START: tv_rst=1 for exactly one cycle, then -> WAIT and the cycle counter clears.
- WAIT: tv_exp_change is ignored in the first WAIT cycle. From the second cycle on, tv_exp_change=1 captures tv_exp and tv_act, sets res_valid=1 and res_timeout=0, and goes -> DONE. If the counter reaches TIMEOUT first: res_valid=1, res_timeout=1, res_exp=0, res_act=0, -> DONE. exp_change on the same cycle as the timeout wins.
- DONE: results are held stable. res_ack -> IDLE and clears res_valid. If load_start and res_ack arrive together, load_start wins.
- busy=1 in CONF, LOAD, START and WAIT.
- Counter width is $clog2(TIMEOUT+1); the counter saturates and never wraps.

Decomposition:
- treeval_pkg holds:
  - the width localparams
  - the cmd_kind enum (KIND_PAR/REW/ACT/WEIGHT)
  - the controller state enum
  - ACT_PLAY=3'b001 and ACT_NO_PLAY=3'b000
- The block is shared by treeval and treeval_ctrl. No sub-module is needed; the strobe register, drop check and timeout counter stay inline.

Test Plan:
- Full load against real treeval:
  - load_nodes=7.
  - PAR 1,2,3->0 and 4,5,6->1.
  - REW 2=-10, 3=0, 4=100, 5=-50, 6=10.
  - ACT 1,2,4,5=PLAY and 3,6=NO_PLAY.
  - WEIGHT 1,2,4,5=64 and 3,6=128, cmd_last on the final write.
  - Expected: tv_conf_nodes for one cycle with data 7, then 23 single-cycle strobes in order, then one tv_rst cycle, then res_valid=1, res_act=3'b001, res_timeout=0.
- Back-to-back: 6 PAR writes on consecutive cycles -> tv_mem_par high for 6 consecutive cycles, addr 1..6, data 0,0,0,1,1,1, other strobes 0.
- Drop: load_nodes=7, REW addr 9 and WEIGHT addr 0 -> no strobes, err_addr=1. A subsequent valid write still forwards.
- Timeout: TIMEOUT=16, treeval stub holds exp_change=0 -> res_valid and res_timeout rise after 16 WAIT cycles, res_exp=0. res_ack -> IDLE and res_valid=0.
- Reset mid-LOAD: drive rst=0 for one cycle after 3 accepted writes -> all strobes 0, cmd_ready=0, state IDLE. A fresh load then completes normally.
- Ignore rules: load_start during WAIT has no effect. load_start together with res_ack in DONE -> CONF, with tv_conf_nodes pulsed the next cycle.
